cpu_control: RTL
================

Name: cpu_control

Overview:
- Instruction register, decoder and multicycle control FSM for the 16-bit CPU.
- Sits directly upstream of the datapath and drives every datapath control input.
- Also drives the fetch/memory side: the PC, the address register and the memory command.
- Sequences fetch, decode, execute and writeback for MOV, ALU, LDR, STR and HALT instructions.

Parameters:
HALT_ON_ILLEGAL, 1, 1: an undecodable opcode enters HALT and sets illegal; 0: it is treated as a NOP and the FSM returns to IF1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
read_data  input  16  memory read data; carries the instruction during fetch
mem_cmd  output  2  memory command: 00 none, 01 read, 10 write
addr_sel  output  1  1 selects PC as the memory address, 0 selects the address register
load_pc  output  1  PC load enable
reset_pc  output  1  forces the next PC value to 0
load_addr  output  1  address register load enable (loads datapath_out[8:0])
readnum  output  3  register file read index
writenum  output  3  register file write index
write  output  1  register file write enable
loada, loadb, loadc, loads  output  1 each  datapath register load enables
asel, bsel  output  1 each  datapath A and B operand selects
vsel  output  2  writeback select: 00 C, 01 PC, 10 sximm8, 11 mdata
shift  output  2  IR[4:3]
shift_ctrl  output  1  forces the datapath shifter to no-shift
ALUop  output  2  IR[12:11]
sximm5  output  16  sign-extended IR[4:0]
sximm8  output  16  sign-extended IR[7:0]
halted  output  1  1 while in HALT
illegal  output  1  sticky; set when an illegal opcode is decoded

Behaviour:
Reset:
- reset=1 at a clock edge: state goes to RST, IR clears to 0, illegal clears to 0.
- While reset=1, every output is 0. Reset mid-instruction aborts the instruction; no register write occurs.

IR fields:
- opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
- sximm5, sximm8, shift and ALUop are combinational from IR and valid in every state.
- readnum/writenum are driven from Rn, Rd or Rm as each state requires, otherwise 0.

Control outputs: any control not listed for a state is 0 in that state.

Fetch sequence (every instruction):
- RST: reset_pc=1, load_pc=1 -> IF1.
- IF1: addr_sel=1, mem_cmd=01 -> IF2.
- IF2: addr_sel=1, mem_cmd=01; IR loads read_data at the end of this cycle -> UPD_PC.
- UPD_PC: load_pc=1 -> DECODE.

DECODE dispatch (DECODE asserts no outputs):
- opcode 110, op 10 (MOV Rn,#imm8) -> WR_IMM: vsel=10, writenum=Rn, write=1 -> IF1.
- opcode 110, op 00 (MOV Rd,Rm,sh) -> GET_B.
- opcode 101 (ADD/CMP/AND/MVN) -> GET_A.
- opcode 011, op 00 (LDR) or 100, op 00 (STR) -> ADDR_A.
- opcode 111 -> HALT.
- Anything else: illegal, handled per HALT_ON_ILLEGAL.

ALU path:
- GET_A: readnum=Rn, loada=1 -> GET_B.
- GET_B: readnum=Rm, loadb=1 -> EXEC.
- EXEC: loadc=1. MOV sets asel=1 and forces ALUop=00. CMP sets loads=1 instead of loadc.
- From EXEC, CMP -> IF1; all others -> WR_RD.
- WR_RD: vsel=00, writenum=Rd, write=1 -> IF1.

Memory path:
- ADDR_A: readnum=Rn, loada=1 -> ADDR_C.
- ADDR_C: bsel=1, ALUop=00, loadc=1 -> ADDR_L.
- ADDR_L: load_addr=1. LDR -> MEM_RD; STR -> STR_B.
- MEM_RD: addr_sel=0, mem_cmd=01 -> WB_MEM.
- WB_MEM: mem_cmd=01, vsel=11, writenum=Rd, write=1 -> IF1.
- STR_B: readnum=Rd, loadb=1 -> STR_C.
- STR_C: shift_ctrl=1, asel=1, ALUop=00, loadc=1 -> MEM_WR.
- MEM_WR: addr_sel=0, mem_cmd=10 -> IF1.

HALT:
- halted=1, all other outputs 0.
- Remains in HALT until reset; clk edges alone never leave it.

Cycles from IF1 to the next IF1:
- MOV imm: 5. MOV reg: 7. ADD/AND/MVN: 8. CMP: 7. LDR: 9. STR: 10.

Test Plan:
- Reset held 3 cycles then released -> all outputs 0 during reset; RST cycle has reset_pc=1 and load_pc=1; IF1 follows with mem_cmd=01, addr_sel=1.
- read_data=16'hD207 (MOV R2,#7) -> WR_IMM cycle shows vsel=10, writenum=2, write=1, sximm8=16'h0007; back in IF1 5 cycles after the previous IF1.
- read_data=16'hA0A1 (ADD R5,R0,R1) -> GET_A readnum=0, GET_B readnum=1, EXEC loadc=1 ALUop=00, WR_RD writenum=5 write=1; 8-cycle loop.
- read_data=16'hA901 (CMP R1,R1) -> EXEC shows loads=1 with loadc=0; no write=1 cycle before the next IF1.
- read_data=16'h811F (STR R0,[R1,#-1]) -> sximm5=16'hFFFF; STR_C shows shift_ctrl=1; MEM_WR shows mem_cmd=10, addr_sel=0; 10-cycle loop.
- read_data=16'hE000 (HALT) -> halted=1 held for 20 cycles with mem_cmd=00; reset=1 then returns to RST.
- read_data=16'h0000 (illegal opcode) with HALT_ON_ILLEGAL=1 -> illegal=1, halted=1.

Source files
------------

// File: rtl/cpu_control_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_control_if
//  Brief    : Bundles the memory-side and datapath-side signals driven by
//             cpu_control. The master is the controller; the slave is the
//             datapath/memory side.
//  Revision : 1.0 - initial release
// ============================================================================
interface cpu_control_if;
    logic [15:0] read_data;
    logic [1:0]  mem_cmd;
    logic        addr_sel;
    logic        load_pc;
    logic        reset_pc;
    logic        load_addr;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic        shift_ctrl;
    logic [1:0]  ALUop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic        halted;
    logic        illegal;

    modport master (
        input  read_data,
        output mem_cmd, addr_sel, load_pc, reset_pc, load_addr,
        output readnum, writenum, write,
        output loada, loadb, loadc, loads, asel, bsel,
        output vsel, shift, shift_ctrl, ALUop, sximm5, sximm8,
        output halted, illegal
    );

    modport slave (
        output read_data,
        input  mem_cmd, addr_sel, load_pc, reset_pc, load_addr,
        input  readnum, writenum, write,
        input  loada, loadb, loadc, loads, asel, bsel,
        input  vsel, shift, shift_ctrl, ALUop, sximm5, sximm8,
        input  halted, illegal
    );
endinterface
`default_nettype wire

// File: rtl/cpu_control.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_control
//  Brief    : Instruction register, decoder and multicycle control FSM for
//             the 16-bit CPU (MOV, ALU, LDR, STR, HALT).
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        reset,
    cpu_control_if.master    bus
);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE, S_WR_IMM,
        S_GET_A, S_GET_B, S_EXEC, S_WR_RD,
        S_ADDR_A, S_ADDR_C, S_ADDR_L, S_MEM_RD, S_WB_MEM,
        S_STR_B, S_STR_C, S_MEM_WR, S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;
    logic        r_illegal;

    // IR field split
    logic [2:0] w_opcode, w_rn, w_rd, w_rm;
    logic [1:0] w_op;
    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_rm     = r_ir[2:0];

    // Instruction classes used by decode and the execute-stage variants
    logic w_mov_imm, w_mov_reg, w_alu, w_mem, w_halt, w_legal, w_is_cmp, w_is_ldr;
    assign w_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_alu     = (w_opcode == 3'b101);
    assign w_mem     = ((w_opcode == 3'b011) || (w_opcode == 3'b100)) && (w_op == 2'b00);
    assign w_halt    = (w_opcode == 3'b111);
    assign w_legal   = w_mov_imm | w_mov_reg | w_alu | w_mem | w_halt;
    assign w_is_cmp  = w_alu && (w_op == 2'b01);
    assign w_is_ldr  = (w_opcode == 3'b011);

    // State, instruction register and sticky illegal flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RST;
            r_ir      <= 16'h0000;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IF2)
                r_ir <= bus.read_data;
            if ((r_state == S_DECODE) && !w_legal)
                r_illegal <= 1'b1;
        end
    end

    logic [1:0]  w_mem_cmd, w_vsel, w_shift, w_aluop;
    logic        w_addr_sel, w_load_pc, w_reset_pc, w_load_addr, w_write;
    logic        w_loada, w_loadb, w_loadc, w_loads, w_asel, w_bsel;
    logic        w_shift_ctrl, w_halted, w_illegal;
    logic [2:0]  w_readnum, w_writenum;
    logic [15:0] w_sximm5, w_sximm8;

    // Next-state and per-state control decode; everything forced low in reset
    always_comb begin
        w_next       = r_state;
        w_mem_cmd    = 2'b00;
        w_addr_sel   = 1'b0;
        w_load_pc    = 1'b0;
        w_reset_pc   = 1'b0;
        w_load_addr  = 1'b0;
        w_readnum    = 3'd0;
        w_writenum   = 3'd0;
        w_write      = 1'b0;
        w_loada      = 1'b0;
        w_loadb      = 1'b0;
        w_loadc      = 1'b0;
        w_loads      = 1'b0;
        w_asel       = 1'b0;
        w_bsel       = 1'b0;
        w_vsel       = 2'b00;
        w_shift      = r_ir[4:3];
        w_shift_ctrl = 1'b0;
        w_aluop      = w_op;
        w_sximm5     = {{11{r_ir[4]}}, r_ir[4:0]};
        w_sximm8     = {{8{r_ir[7]}}, r_ir[7:0]};
        w_halted     = 1'b0;
        w_illegal    = r_illegal;

        case (r_state)
            S_RST: begin
                w_reset_pc = 1'b1;
                w_load_pc  = 1'b1;
                w_next     = S_IF1;
            end
            S_IF1: begin
                w_addr_sel = 1'b1;
                w_mem_cmd  = 2'b01;
                w_next     = S_IF2;
            end
            S_IF2: begin
                w_addr_sel = 1'b1;
                w_mem_cmd  = 2'b01;
                w_next     = S_UPD_PC;
            end
            S_UPD_PC: begin
                w_load_pc = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                if (w_mov_imm)      w_next = S_WR_IMM;
                else if (w_mov_reg) w_next = S_GET_B;
                else if (w_alu)     w_next = S_GET_A;
                else if (w_mem)     w_next = S_ADDR_A;
                else if (w_halt)    w_next = S_HALT;
                else                w_next = HALT_ON_ILLEGAL ? S_HALT : S_IF1;
            end
            S_WR_IMM: begin
                w_vsel     = 2'b10;
                w_writenum = w_rn;
                w_write    = 1'b1;
                w_next     = S_IF1;
            end
            S_GET_A: begin
                w_readnum = w_rn;
                w_loada   = 1'b1;
                w_next    = S_GET_B;
            end
            S_GET_B: begin
                w_readnum = w_rm;
                w_loadb   = 1'b1;
                w_next    = S_EXEC;
            end
            S_EXEC: begin
                // CMP only updates status; MOV passes B through with A ignored
                w_loadc = !w_is_cmp;
                w_loads = w_is_cmp;
                if (w_mov_reg) begin
                    w_asel  = 1'b1;
                    w_aluop = 2'b00;
                end
                w_next = w_is_cmp ? S_IF1 : S_WR_RD;
            end
            S_WR_RD: begin
                w_writenum = w_rd;
                w_write    = 1'b1;
                w_next     = S_IF1;
            end
            S_ADDR_A: begin
                w_readnum = w_rn;
                w_loada   = 1'b1;
                w_next    = S_ADDR_C;
            end
            S_ADDR_C: begin
                w_bsel  = 1'b1;
                w_aluop = 2'b00;
                w_loadc = 1'b1;
                w_next  = S_ADDR_L;
            end
            S_ADDR_L: begin
                w_load_addr = 1'b1;
                w_next      = w_is_ldr ? S_MEM_RD : S_STR_B;
            end
            S_MEM_RD: begin
                w_mem_cmd = 2'b01;
                w_next    = S_WB_MEM;
            end
            S_WB_MEM: begin
                w_mem_cmd  = 2'b01;
                w_vsel     = 2'b11;
                w_writenum = w_rd;
                w_write    = 1'b1;
                w_next     = S_IF1;
            end
            S_STR_B: begin
                w_readnum = w_rd;
                w_loadb   = 1'b1;
                w_next    = S_STR_C;
            end
            S_STR_C: begin
                // Store data passes through the ALU unshifted as 0 + Rd
                w_shift_ctrl = 1'b1;
                w_asel       = 1'b1;
                w_aluop      = 2'b00;
                w_loadc      = 1'b1;
                w_next       = S_MEM_WR;
            end
            S_MEM_WR: begin
                w_mem_cmd = 2'b10;
                w_next    = S_IF1;
            end
            S_HALT: begin
                w_halted = 1'b1;
                w_next   = S_HALT;
            end
            default: w_next = S_RST;
        endcase

        if (reset) begin
            w_mem_cmd    = 2'b00;
            w_addr_sel   = 1'b0;
            w_load_pc    = 1'b0;
            w_reset_pc   = 1'b0;
            w_load_addr  = 1'b0;
            w_readnum    = 3'd0;
            w_writenum   = 3'd0;
            w_write      = 1'b0;
            w_loada      = 1'b0;
            w_loadb      = 1'b0;
            w_loadc      = 1'b0;
            w_loads      = 1'b0;
            w_asel       = 1'b0;
            w_bsel       = 1'b0;
            w_vsel       = 2'b00;
            w_shift      = 2'b00;
            w_shift_ctrl = 1'b0;
            w_aluop      = 2'b00;
            w_sximm5     = 16'h0000;
            w_sximm8     = 16'h0000;
            w_halted     = 1'b0;
            w_illegal    = 1'b0;
        end
    end

    assign bus.mem_cmd    = w_mem_cmd;
    assign bus.addr_sel   = w_addr_sel;
    assign bus.load_pc    = w_load_pc;
    assign bus.reset_pc   = w_reset_pc;
    assign bus.load_addr  = w_load_addr;
    assign bus.readnum    = w_readnum;
    assign bus.writenum   = w_writenum;
    assign bus.write      = w_write;
    assign bus.loada      = w_loada;
    assign bus.loadb      = w_loadb;
    assign bus.loadc      = w_loadc;
    assign bus.loads      = w_loads;
    assign bus.asel       = w_asel;
    assign bus.bsel       = w_bsel;
    assign bus.vsel       = w_vsel;
    assign bus.shift      = w_shift;
    assign bus.shift_ctrl = w_shift_ctrl;
    assign bus.ALUop      = w_aluop;
    assign bus.sximm5     = w_sximm5;
    assign bus.sximm8     = w_sximm8;
    assign bus.halted     = w_halted;
    assign bus.illegal    = w_illegal;

endmodule
`default_nettype wire
